// File: rtl/bsg_manycore_pkg.sv
// -----------------------------------------------------------------------------
// bsg_manycore_pkg
// Shared constants, types and helpers for the manycore ruche-link arbiter.
//   bsg_manycore_ruche_arb_cnt_width_gp : width of each per-input grant counter
//   bsg_manycore_ruche_arb_cnt_t        : grant counter type
//   bsg_manycore_ruche_arb_sat_inc()    : saturating counter increment
// The counters exist only when BSG_MANYCORE_RUCHE_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
package bsg_manycore_pkg;

   localparam int bsg_manycore_ruche_arb_cnt_width_gp = 16;

   typedef logic [bsg_manycore_ruche_arb_cnt_width_gp-1:0] bsg_manycore_ruche_arb_cnt_t;

   // Sticks at all-ones instead of wrapping back to zero.
   function automatic bsg_manycore_ruche_arb_cnt_t bsg_manycore_ruche_arb_sat_inc
      (input bsg_manycore_ruche_arb_cnt_t cnt);
      return (&cnt) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/bsg_manycore_ruche_link_arbiter_if.sv
// -----------------------------------------------------------------------------
// bsg_manycore_ruche_link_arbiter_if
// Handshake bundle between num_in_p requesters, the arbiter and the outgoing
// ruche-X link. Signal directions are named from the arbiter's point of view.
//   v_i     [num_in_p]          per-requester valid
//   data_i  [num_in_p*width_p]  requester i at bits [i*width_p +: width_p]
//   ready_o [num_in_p]          per-requester accept
//   v_o                         link valid (registered)
//   data_o  [width_p]           link packet (registered)
//   ready_i                     link accept
// Modports: slave = arbiter side, master = requester/link environment side.
// No configuration macros affect this file.
// -----------------------------------------------------------------------------
interface bsg_manycore_ruche_link_arbiter_if
   #(parameter int num_in_p = 2,
     parameter int width_p  = 64);

   logic [num_in_p-1:0]         v_i;
   logic [num_in_p*width_p-1:0] data_i;
   logic [num_in_p-1:0]         ready_o;
   logic                        v_o;
   logic [width_p-1:0]          data_o;
   logic                        ready_i;

   modport slave  (input  v_i, data_i, ready_i,
                   output ready_o, v_o, data_o);

   modport master (output v_i, data_i, ready_i,
                   input  ready_o, v_o, data_o);

endinterface

// File: rtl/bsg_manycore_ruche_rr_pick.sv
// -----------------------------------------------------------------------------
// bsg_manycore_ruche_rr_pick
// Purely combinational round-robin pick: finds the first set bit of v_i
// starting at (last_i+1) mod num_in_p and wrapping around.
//   v_i     [num_in_p]           request vector
//   last_i  [$clog2(num_in_p)]   index granted most recently
//   grant_o [num_in_p]           one-hot grant (all zero when no request)
//   idx_o   [$clog2(num_in_p)]   encoded grant index (zero when no request)
// No configuration macros affect this file.
// -----------------------------------------------------------------------------
module bsg_manycore_ruche_rr_pick
   import bsg_manycore_pkg::*;
   #(parameter int num_in_p = 2)
   (input  logic [num_in_p-1:0]         v_i,
    input  logic [$clog2(num_in_p)-1:0] last_i,
    output logic [num_in_p-1:0]         grant_o,
    output logic [$clog2(num_in_p)-1:0] idx_o);

   localparam int lg_lp = $clog2(num_in_p);

   typedef logic [lg_lp-1:0]    idx_t;
   typedef logic [lg_lp:0]      shift_t;
   typedef logic [num_in_p-1:0] vec_t;

   shift_t shift;
   vec_t   rot;
   logic   found;
   int     pos;

   always_comb begin
      // Rotate the doubled request vector so bit 0 is the highest-priority
      // candidate; last_i+1 may equal num_in_p, which simply means no rotation.
      shift   = {1'b0, last_i} + shift_t'(1);
      rot     = vec_t'({v_i, v_i} >> shift);
      found   = 1'b0;
      pos     = 0;
      grant_o = '0;
      idx_o   = '0;
      for (int j = 0; j < num_in_p; j++) begin
         if (!found && rot[j]) begin
            found = 1'b1;
            pos   = int'(last_i) + 1 + j;
            if (pos >= num_in_p) pos = pos - num_in_p;
         end
      end
      if (found) begin
         idx_o   = idx_t'(pos);
         grant_o = vec_t'(1) << idx_o;
      end
   end

endmodule

// File: rtl/bsg_manycore_ruche_link_arbiter.sv
// -----------------------------------------------------------------------------
// bsg_manycore_ruche_link_arbiter
// Round-robin arbiter merging num_in_p requesters onto one outgoing ruche-X
// link through a single output register (one-cycle latency, full throughput).
//   clk_i          clock, all state on the rising edge
//   reset_i        asynchronous active-high reset
//   link           handshake bundle (slave modport), see the interface file
//   grant_count_o  [num_in_p*16] saturating per-input accept counters; present
//                  only when BSG_MANYCORE_RUCHE_ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
module bsg_manycore_ruche_link_arbiter
   import bsg_manycore_pkg::*;
   #(parameter int num_in_p = 2,
     parameter int width_p  = 64)
   (input  logic clk_i,
    input  logic reset_i,
    bsg_manycore_ruche_link_arbiter_if.slave link
`ifdef BSG_MANYCORE_RUCHE_ARB_STATS_EN
    ,output logic [num_in_p*bsg_manycore_ruche_arb_cnt_width_gp-1:0] grant_count_o
`endif
   );

   localparam int lg_lp = $clog2(num_in_p);

   typedef logic [lg_lp-1:0] idx_t;

   // Input 0 wins first after reset because the search starts at last+1.
   localparam idx_t last_rst_lp = idx_t'(num_in_p-1);

   logic [num_in_p-1:0] grant;
   idx_t                grant_idx;
   logic [num_in_p-1:0] ready;
   logic                open;
   logic                accept;
   logic [width_p-1:0]  sel_data;

   logic                armed_q;
   logic                v_q, v_d;
   logic [width_p-1:0]  data_q, data_d;
   idx_t                last_q, last_d;

   bsg_manycore_ruche_rr_pick #(.num_in_p(num_in_p)) pick
      (.v_i    (link.v_i),
       .last_i (last_q),
       .grant_o(grant),
       .idx_o  (grant_idx));

   // armed_q keeps ready_o low until the first edge after reset release, so
   // nothing is accepted while the reset is still settling.
   assign open         = ~v_q | link.ready_i;
   assign ready        = grant & {num_in_p{open & armed_q}};
   assign accept       = |ready;
   assign link.ready_o = ready;
   assign link.v_o     = v_q;
   assign link.data_o  = data_q;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < num_in_p; i++) begin
         if (grant[i]) sel_data = sel_data | link.data_i[i*width_p +: width_p];
      end
      v_d    = v_q;
      data_d = data_q;
      last_d = last_q;
      if (accept) begin
         v_d    = 1'b1;
         data_d = sel_data;
         last_d = grant_idx;
      end else if (link.ready_i) begin
         v_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         armed_q <= 1'b0;
         v_q     <= 1'b0;
         data_q  <= '0;
         last_q  <= last_rst_lp;
      end else begin
         armed_q <= 1'b1;
         v_q     <= v_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

`ifdef BSG_MANYCORE_RUCHE_ARB_STATS_EN
   bsg_manycore_ruche_arb_cnt_t [num_in_p-1:0] cnt_q, cnt_d;

   always_comb begin
      for (int i = 0; i < num_in_p; i++) begin
         cnt_d[i] = ready[i] ? bsg_manycore_ruche_arb_sat_inc(cnt_q[i]) : cnt_q[i];
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign grant_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_bsg_manycore_ruche_link_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bsg_manycore_ruche_link_arbiter
// Bench for the ruche-link arbiter with num_in_p=4, width_p=16. Expected link
// packets are queued when a grant is expected and popped by an independent
// output monitor whenever the link transfers.
// -----------------------------------------------------------------------------
module tb_bsg_manycore_ruche_link_arbiter;

   localparam int NI = 4;
   localparam int W  = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bsg_manycore_ruche_link_arbiter_if #(.num_in_p(NI), .width_p(W)) lif ();

   logic [W-1:0] dat [NI];
   for (genvar g = 0; g < NI; g++) begin : g_dat
      assign lif.data_i[g*W +: W] = dat[g];
   end

`ifdef BSG_MANYCORE_RUCHE_ARB_STATS_EN
   logic [NI*16-1:0] gcnt;
`endif

   bsg_manycore_ruche_link_arbiter #(.num_in_p(NI), .width_p(W)) dut
      (.clk_i  (clk),
       .reset_i(rst),
       .link   (lif.slave)
`ifdef BSG_MANYCORE_RUCHE_ARB_STATS_EN
       ,.grant_count_o(gcnt)
`endif
      );

   int           n_chk  = 0;
   int           n_fail = 0;
   logic [W-1:0] expq [$];
   logic [W-1:0] e_mon;
   bit           mon_en = 1'b1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Output monitor: every link transfer must match the oldest expected packet.
   always @(negedge clk) begin
      if (mon_en && !rst && lif.v_o && lif.ready_i) begin
         n_chk++;
         if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected: got %0h expected none (t=%0t)", lif.data_o, $time);
         end else begin
            e_mon = expq.pop_front();
            if (lif.data_o !== e_mon) begin
               n_fail++;
               $display("FAIL out_data: got %0h expected %0h (t=%0t)", lif.data_o, e_mon, $time);
            end
         end
      end
   end

   // One cycle: inputs change just after the edge, grant is checked mid-cycle.
   task automatic cyc(input logic [NI-1:0] v, input logic rdy, input logic [NI-1:0] exp_rdy,
                      input logic [W-1:0] base, input bit push, input string nm);
      @(posedge clk);
      #1;
      lif.v_i     = v;
      lif.ready_i = rdy;
      for (int i = 0; i < NI; i++) dat[i] = base + W'(i);
      @(negedge clk);
      chk(nm, 64'(lif.ready_o), 64'(exp_rdy));
      if (push) begin
         for (int i = 0; i < NI; i++) if (exp_rdy[i]) expq.push_back(dat[i]);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst         = 1'b1;
      lif.v_i     = '0;
      lif.ready_i = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Random-phase reference model state.
   logic         mv;
   int           mlast;
   logic [11:0]  seq [NI];
   int           wait_cnt [NI];
   int           g;
   bit           fnd;
   logic [NI-1:0] exp_r;

   initial begin
      rst         = 1'b1;
      lif.v_i     = 4'b1111;
      lif.ready_i = 1'b1;
      for (int i = 0; i < NI; i++) dat[i] = 16'h0F00 + W'(i);

      // Reset state with every requester asserting.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_v_o",     64'(lif.v_o),     64'd0);
      chk("rst_data_o",  64'(lif.data_o),  64'd0);
      chk("rst_ready_o", 64'(lif.ready_o), 64'd0);

      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_before_first_edge", 64'(lif.ready_o), 64'd0);

      // All four requesting: strict rotation starting at input 0.
      for (int k = 0; k < 2; k++) begin
         cyc(4'b1111, 1'b1, 4'b0001, 16'h1100, 1'b1, "rr_all_g0");
         cyc(4'b1111, 1'b1, 4'b0010, 16'h1100, 1'b1, "rr_all_g1");
         cyc(4'b1111, 1'b1, 4'b0100, 16'h1100, 1'b1, "rr_all_g2");
         cyc(4'b1111, 1'b1, 4'b1000, 16'h1100, 1'b1, "rr_all_g3");
      end

      // Sparse requests 1010: alternate 1,3; inputs 0 and 2 never see ready.
      cyc(4'b1010, 1'b1, 4'b0010, 16'h2200, 1'b1, "sparse_g1a");
      cyc(4'b1010, 1'b1, 4'b1000, 16'h2200, 1'b1, "sparse_g3a");
      cyc(4'b1010, 1'b1, 4'b0010, 16'h2200, 1'b1, "sparse_g1b");
      cyc(4'b1010, 1'b1, 4'b1000, 16'h2200, 1'b1, "sparse_g3b");

      // Backpressure: 0xA5 held while all others request; priority must not move.
      cyc(4'b0001, 1'b1, 4'b0001, 16'h00A5, 1'b1, "load_a5");
      for (int k = 0; k < 5; k++) begin
         cyc(4'b1111, 1'b0, 4'b0000, 16'h00A5, 1'b1, "hold_ready");
         chk("hold_data", 64'(lif.data_o), 64'h00A5);
         chk("hold_v",    64'(lif.v_o),    64'd1);
      end
      cyc(4'b1111, 1'b1, 4'b0010, 16'h3300, 1'b1, "after_hold_g1");
      cyc(4'b1111, 1'b1, 4'b0100, 16'h3300, 1'b1, "after_hold_g2");
      cyc(4'b0000, 1'b1, 4'b0000, 16'h3300, 1'b1, "drain");

      // Asynchronous reset while a packet is held on the link.
      cyc(4'b0001, 1'b1, 4'b0001, 16'h4400, 1'b0, "pre_async_g0");
      cyc(4'b0000, 1'b0, 4'b0000, 16'h4400, 1'b0, "pre_async_hold");
      chk("pre_async_v", 64'(lif.v_o), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_v_o",     64'(lif.v_o),     64'd0);
      chk("async_data_o",  64'(lif.data_o),  64'd0);
      chk("async_ready_o", 64'(lif.ready_o), 64'd0);
      @(posedge clk);
      #1;
      rst         = 1'b0;
      lif.v_i     = 4'b1111;
      lif.ready_i = 1'b1;
      @(negedge clk);
      chk("ready_after_async_release", 64'(lif.ready_o), 64'd0);
      cyc(4'b1111, 1'b1, 4'b0001, 16'h5500, 1'b1, "post_rst_g0");
      cyc(4'b1111, 1'b1, 4'b0010, 16'h5500, 1'b1, "post_rst_g1");
      cyc(4'b0000, 1'b1, 4'b0000, 16'h5500, 1'b1, "post_rst_drain");
      repeat (2) @(negedge clk);
      chk("directed_queue_empty", 64'(expq.size()), 64'd0);

      // Random traffic against a behavioural round-robin model.
      do_reset();
      mv    = 1'b0;
      mlast = NI-1;
      for (int i = 0; i < NI; i++) begin
         seq[i]      = '0;
         wait_cnt[i] = 0;
      end
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         lif.v_i     = NI'($urandom);
         lif.ready_i = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NI; i++) dat[i] = {4'(i), seq[i]};
         @(negedge clk);
         fnd = 1'b0;
         g   = 0;
         for (int k = 1; k <= NI; k++) begin
            if (!fnd && lif.v_i[(mlast+k)%NI]) begin
               fnd = 1'b1;
               g   = (mlast+k)%NI;
            end
         end
         exp_r = (fnd && (!mv || lif.ready_i)) ? (NI'(1) << g) : '0;
         chk("rnd_v_o",     64'(lif.v_o),     64'(mv));
         chk("rnd_ready_o", 64'(lif.ready_o), 64'(exp_r));
         if (exp_r != 0) begin
            expq.push_back(dat[g]);
            for (int i = 0; i < NI; i++) begin
               if (i == g)          wait_cnt[i] = 0;
               else if (lif.v_i[i]) wait_cnt[i]++;
            end
            seq[g]++;
            mlast = g;
            mv    = 1'b1;
         end else if (lif.ready_i) begin
            mv = 1'b0;
         end
         for (int i = 0; i < NI; i++) begin
            if (!lif.v_i[i]) wait_cnt[i] = 0;
            chk("rnd_fair_wait", 64'(wait_cnt[i] > NI-1), 64'd0);
         end
      end
      @(posedge clk);
      #1;
      lif.v_i     = '0;
      lif.ready_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("random_queue_empty", 64'(expq.size()), 64'd0);

`ifdef BSG_MANYCORE_RUCHE_ARB_STATS_EN
      // 70000 accepts from input 0 saturate its counter; input 1 stays zero.
      mon_en = 1'b0;
      do_reset();
      @(negedge clk);
      chk("stats_rst", 64'(gcnt), 64'd0);
      lif.v_i     = 4'b0001;
      lif.ready_i = 1'b1;
      repeat (70001) @(posedge clk);
      @(negedge clk);
      chk("stats_cnt0", 64'(gcnt[15:0]),  64'hFFFF);
      chk("stats_cnt1", 64'(gcnt[31:16]), 64'd0);
      lif.v_i = '0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bsg_manycore_ruche_link_arbiter.md
BSG_MANYCORE_RUCHE_LINK_ARBITER -- requirements
Module: bsg_manycore_ruche_link_arbiter

Interface
REQ-001 Parameter num_in_p, default 2: number of requesters sharing one outgoing ruche-X link; legal range 2..8.
REQ-002 Parameter width_p, default 64: packet width in bits; one packet is one transfer.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 v_i  input  num_in_p  per-requester valid.
REQ-006 data_i  input  num_in_p*width_p  per-requester packet; requester i occupies bits [i*width_p +: width_p].
REQ-007 ready_o  output  num_in_p  per-requester accept; input i transfers when v_i[i] & ready_o[i].
REQ-008 v_o  output  1  registered output valid.
REQ-009 data_o  output  width_p  registered output packet.
REQ-010 ready_i  input  1  downstream accept; output transfers when v_o & ready_i.

Function
REQ-011 Output stage: one register (v_r, data_r) drives v_o and data_o directly; no combinational path from data_i to data_o.
REQ-012 Stage open when ~v_r | ready_i.
REQ-013 At most one ready_o bit high per cycle.
REQ-014 ready_o[i] = grant[i] & stage open.
REQ-015 grant selects the first requester with v_i high, searching from index (last_r+1) mod num_in_p upward with wrap-around.
REQ-016 On an input transfer, data_r loads the granted packet, v_r=1, and last_r takes the granted index.
REQ-017 With no input transfer and ready_i high, v_r clears to 0.
REQ-018 With ready_i low and v_r high, v_r, data_r and last_r hold.
REQ-019 Simultaneous output drain and input accept in one cycle gives back-to-back transfers at full throughput, one packet per cycle.
REQ-020 last_r changes only on an accepted transfer; a request that is presented and then withdrawn does not move priority.
REQ-021 Latency is one cycle: a packet accepted in cycle N appears on v_o/data_o in cycle N+1.
REQ-022 Fairness: a continuously-requesting input waits at most num_in_p-1 accepted transfers between its own grants.
REQ-023 Packet content passes through unmodified.

Reset
REQ-024 While reset_i is high: v_o=0, data_o=0, ready_o=0, and last_r=num_in_p-1, so input 0 has first priority.
REQ-025 Asserting reset mid-transfer discards the registered packet immediately, without waiting for a clock edge.
REQ-026 ready_o stays 0 until the first clock edge after reset_i deasserts.

Configuration
REQ-027 Macro BSG_MANYCORE_RUCHE_ARB_STATS_EN, when defined, adds output port grant_count_o  num_in_p*16: one saturating counter per input, incremented on each accepted transfer from that input.
REQ-028 Each grant counter resets to 0 and holds at 16'hFFFF once it reaches that value.
REQ-029 When BSG_MANYCORE_RUCHE_ARB_STATS_EN is undefined, the port and counters do not exist; all other behaviour is identical.

Structure
REQ-030 Counter width constant bsg_manycore_ruche_arb_cnt_width_gp = 16 lives in bsg_manycore_pkg.
REQ-031 The wrap-around priority search is sub-module bsg_manycore_ruche_rr_pick.
REQ-032 bsg_manycore_ruche_rr_pick is purely combinational: inputs v_i and last index, outputs one-hot grant and encoded index.
REQ-033 No FIFOs beyond the single output register.

Verification
REQ-034 Reset, then v_i=2'b11 held, ready_i=1 (num_in_p=2) -> grants alternate 0,1,0,1; v_o high every cycle from cycle 2.
REQ-035 num_in_p=4, v_i=4'b1010, ready_i=1 -> grant order 1,3,1,3; inputs 0 and 2 never get ready_o.
REQ-036 Output holding packet 0xA5, ready_i=0 for 5 cycles -> data_o stays 0xA5, ready_o=0, last_r unchanged; ready_i=1 -> next grant moves to the following requester.
REQ-037 reset_i asserted asynchronously between clock edges while v_o=1 -> v_o falls without waiting for an edge; after release, first grant goes to input 0.
REQ-038 With BSG_MANYCORE_RUCHE_ARB_STATS_EN defined, 70000 transfers from input 0 -> grant_count_o[0]=16'hFFFF, grant_count_o[1]=0.
REQ-039 Random v_i/ready_i for 10^5 cycles, with a scoreboard per input -> no packet lost, duplicated or reordered per input, and the REQ-022 wait bound is never exceeded.
